// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two ALU requesters, the response consumer and alu_arbiter.
// The arbiter takes the slave side; requesters and consumer take the master side.
interface alu_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [2:0]       req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;

    logic             req1_valid;
    logic             req1_ready;
    logic [2:0]       req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_cout;
    logic             rsp_id;
    logic             rsp_err;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_data, rsp_cout, rsp_id, rsp_err
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_data, rsp_cout, rsp_id, rsp_err
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters, one op in flight.
// Define ALU_ARB_SEQ_MUL_EN to run op 110 as a shift-add multiply through the ALU adder.
module alu_arbiter #(
    parameter int WIDTH   = 32,
    parameter bit RR_INIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_arbiter_if.slave     bus,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_dout,
    input  logic             alu_cout
);

    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;

`ifdef ALU_ARB_SEQ_MUL_EN
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam int         CNT_W  = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2,
        ST_MUL  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;
`endif

    function automatic logic op_illegal(input logic [2:0] op);
`ifdef ALU_ARB_SEQ_MUL_EN
        op_illegal = (op == 3'b111);
`else
        op_illegal = (op[2:1] == 2'b11);
`endif
    endfunction

    // Only ADD and SUB report a carry; other ops leave the ALU carry meaningless.
    function automatic logic op_has_carry(input logic [2:0] op);
        op_has_carry = (op == OP_ADD) || (op == OP_SUB);
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic             rr_ptr_r;
    logic             tie_s;
    logic             grant_s;
    logic             accept_s;
    logic             ready0_s;
    logic             ready1_s;
    logic [2:0]       sel_op_s;
    logic [WIDTH-1:0] sel_a_s;
    logic [WIDTH-1:0] sel_b_s;

    logic [WIDTH-1:0] alu_a_r;
    logic [WIDTH-1:0] alu_b_r;
    logic [2:0]       alu_ctrl_r;
    logic             rsp_valid_r;
    logic [WIDTH-1:0] rsp_data_r;
    logic             rsp_cout_r;
    logic             rsp_id_r;
    logic             rsp_err_r;

`ifdef ALU_ARB_SEQ_MUL_EN
    logic [WIDTH-1:0] mplier_r;
    logic [CNT_W-1:0] mul_cnt_r;
    logic [WIDTH-1:0] mul_acc_s;
`endif

    // Arbitration: a lone requester wins, a tie goes to the port named by the pointer.
    always_comb begin
        tie_s    = bus.req0_valid && bus.req1_valid;
        grant_s  = 1'b0;
        sel_op_s = bus.req0_op;
        sel_a_s  = bus.req0_a;
        sel_b_s  = bus.req0_b;
        if (tie_s) begin
            grant_s = rr_ptr_r;
        end else if (bus.req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
        if (grant_s) begin
            sel_op_s = bus.req1_op;
            sel_a_s  = bus.req1_a;
            sel_b_s  = bus.req1_b;
        end else begin
            sel_op_s = bus.req0_op;
            sel_a_s  = bus.req0_a;
            sel_b_s  = bus.req0_b;
        end
    end

    // Next-state and request-ready decode; ready is held low while rst_n is asserted.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        ready0_s    = 1'b0;
        ready1_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rst_n && (bus.req0_valid || bus.req1_valid)) begin
                    accept_s = 1'b1;
                    ready0_s = ~grant_s;
                    ready1_s = grant_s;
                    if (op_illegal(sel_op_s)) begin
                        state_nxt_s = ST_RESP;
`ifdef ALU_ARB_SEQ_MUL_EN
                    end else if (sel_op_s == OP_MUL) begin
                        state_nxt_s = ST_MUL;
`endif
                    end else begin
                        state_nxt_s = ST_EXEC;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EXEC: state_nxt_s = ST_RESP;
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
`ifdef ALU_ARB_SEQ_MUL_EN
            ST_MUL: begin
                if (mul_cnt_r == CNT_LAST) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_MUL;
                end
            end
`endif
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

`ifdef ALU_ARB_SEQ_MUL_EN
    // Shift-add step: the ALU is set up as acc + multiplicand; keep the sum only for a set multiplier bit.
    always_comb begin
        if (mplier_r[0]) begin
            mul_acc_s = alu_dout;
        end else begin
            mul_acc_s = alu_a_r;
        end
    end
`endif

    // Datapath: operand/control registers toward the ALU, round-robin pointer and held response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_r     <= {WIDTH{1'b0}};
            alu_b_r     <= {WIDTH{1'b0}};
            alu_ctrl_r  <= 3'b000;
            rr_ptr_r    <= RR_INIT;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= {WIDTH{1'b0}};
            rsp_cout_r  <= 1'b0;
            rsp_id_r    <= 1'b0;
            rsp_err_r   <= 1'b0;
`ifdef ALU_ARB_SEQ_MUL_EN
            mplier_r    <= {WIDTH{1'b0}};
            mul_cnt_r   <= {CNT_W{1'b0}};
`endif
        end else if (accept_s) begin
            alu_a_r    <= sel_a_s;
            alu_b_r    <= sel_b_s;
            alu_ctrl_r <= sel_op_s;
            rsp_id_r   <= grant_s;
            if (tie_s) begin
                rr_ptr_r <= ~grant_s;
            end
            if (op_illegal(sel_op_s)) begin
                rsp_valid_r <= 1'b1;
                rsp_data_r  <= {WIDTH{1'b0}};
                rsp_cout_r  <= 1'b0;
                rsp_err_r   <= 1'b1;
            end
`ifdef ALU_ARB_SEQ_MUL_EN
            mplier_r  <= sel_b_s;
            mul_cnt_r <= {CNT_W{1'b0}};
`endif
        end else begin
            case (state_r)
                ST_EXEC: begin
                    rsp_valid_r <= 1'b1;
                    rsp_data_r  <= alu_dout;
                    rsp_cout_r  <= op_has_carry(alu_ctrl_r) ? alu_cout : 1'b0;
                    rsp_err_r   <= 1'b0;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                    end
                end
`ifdef ALU_ARB_SEQ_MUL_EN
                ST_MUL: begin
                    mul_cnt_r <= mul_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (mul_cnt_r == {CNT_W{1'b0}}) begin
                        // Setup cycle: acc starts at zero, operand a becomes the multiplicand.
                        alu_a_r    <= {WIDTH{1'b0}};
                        alu_b_r    <= alu_a_r;
                        alu_ctrl_r <= OP_ADD;
                    end else begin
                        alu_a_r  <= mul_acc_s;
                        alu_b_r  <= {alu_b_r[WIDTH-2:0], 1'b0};
                        mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
                        if (mul_cnt_r == CNT_LAST) begin
                            rsp_valid_r <= 1'b1;
                            rsp_data_r  <= mul_acc_s;
                            rsp_cout_r  <= 1'b0;
                            rsp_err_r   <= 1'b0;
                        end
                    end
                end
`endif
                default: begin
                    rsp_valid_r <= rsp_valid_r;
                end
            endcase
        end
    end

    assign bus.req0_ready = ready0_s;
    assign bus.req1_ready = ready1_s;
    assign bus.rsp_valid  = rsp_valid_r;
    assign bus.rsp_data   = rsp_data_r;
    assign bus.rsp_cout   = rsp_cout_r;
    assign bus.rsp_id     = rsp_id_r;
    assign bus.rsp_err    = rsp_err_r;
    assign alu_a          = alu_a_r;
    assign alu_b          = alu_b_r;
    assign alu_ctrl       = alu_ctrl_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed and random requests scored against a result-level model.
// Build with ALU_ARB_SEQ_MUL_EN defined to expect the sequential multiply on op 110.
module tb_alu_arbiter;

    localparam int WIDTH   = 32;
    localparam bit RR_INIT = 1'b0;

    typedef struct {
        logic [31:0] data;
        logic        cout;
        logic        id;
        logic        err;
        int          lat;
        int          acc_cyc;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_dout;
    logic        alu_cout;

    alu_arbiter_if #(.WIDTH(WIDTH)) bus ();

    alu_arbiter #(.WIDTH(WIDTH), .RR_INIT(RR_INIT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_ctrl (alu_ctrl),
        .alu_dout (alu_dout),
        .alu_cout (alu_cout)
    );

    always #5 clk = ~clk;

    // Shared ALU; its carry is deliberately 1 on non-arithmetic codes so unmasked carries show up.
    always_comb begin
        alu_dout = 32'h0000_0000;
        alu_cout = 1'b1;
        case (alu_ctrl)
            3'b000: alu_dout = ~alu_a;
            3'b001: alu_dout = alu_a & alu_b;
            3'b010: alu_dout = $signed(alu_a) >>> alu_b[4:0];
            3'b011: alu_dout = alu_a ^ alu_b;
            3'b100: {alu_cout, alu_dout} = {1'b0, alu_a} + {1'b0, alu_b};
            3'b101: {alu_cout, alu_dout} = {1'b0, alu_a} - {1'b0, alu_b};
            default: alu_dout = 32'hDEAD_BEEF;
        endcase
    end

    function automatic exp_t ref_model(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b, input logic id);
        exp_t        r;
        logic [32:0] w;
        r.data = 32'h0; r.cout = 1'b0; r.id = id; r.err = 1'b0; r.lat = 2; r.acc_cyc = 0;
        case (op)
            3'b000: r.data = ~a;
            3'b001: r.data = a & b;
            3'b010: r.data = $signed(a) >>> b[4:0];
            3'b011: r.data = a ^ b;
            3'b100: begin w = {1'b0, a} + {1'b0, b}; r.data = w[31:0]; r.cout = w[32]; end
            3'b101: begin w = {1'b0, a} - {1'b0, b}; r.data = w[31:0]; r.cout = w[32]; end
`ifdef ALU_ARB_SEQ_MUL_EN
            3'b110: begin r.data = a * b; r.lat = WIDTH + 2; end
`endif
            default: begin r.err = 1'b1; r.lat = 1; end
        endcase
        return r;
    endfunction

    exp_t exp_q[$];
    exp_t mon_e;
    bit   model_idle = 1'b1;
    bit   model_ptr  = RR_INIT;
    bit   head_seen  = 1'b0;
    bit   mon_g, mon_p0, mon_p1;
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;
    bit   end_req  = 1'b0;
    bit   end_done = 1'b0;
    bit   took0, took1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: reset checks, grant prediction, expected-response queueing and response scoring.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            #1;
            chk("rst_flags", 32'({bus.rsp_valid, bus.rsp_cout, bus.rsp_id, bus.rsp_err,
                                  bus.req0_ready, bus.req1_ready, alu_ctrl}), 32'h0);
            chk("rst_rsp_data", bus.rsp_data, 32'h0);
            chk("rst_alu_a", alu_a, 32'h0);
            chk("rst_alu_b", alu_b, 32'h0);
            exp_q.delete();
            model_idle = 1'b1;
            model_ptr  = RR_INIT;
            head_seen  = 1'b0;
        end else begin
            cyc++;
            mon_g  = 1'b0;
            mon_p0 = 1'b0;
            mon_p1 = 1'b0;
            if (model_idle && (bus.req0_valid || bus.req1_valid)) begin
                mon_g  = (bus.req0_valid && bus.req1_valid) ? model_ptr : bus.req1_valid;
                mon_p0 = ~mon_g;
                mon_p1 = mon_g;
            end
            chk("grant", 32'({bus.req1_ready, bus.req0_ready}), 32'({mon_p1, mon_p0}));
            if (mon_p0 || mon_p1) begin
                if (mon_g) mon_e = ref_model(bus.req1_op, bus.req1_a, bus.req1_b, 1'b1);
                else       mon_e = ref_model(bus.req0_op, bus.req0_a, bus.req0_b, 1'b0);
                mon_e.acc_cyc = cyc;
                exp_q.push_back(mon_e);
                model_idle = 1'b0;
                if (bus.req0_valid && bus.req1_valid) model_ptr = ~mon_g;
            end
            if (bus.rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 32'(bus.rsp_valid), 32'h0);
                end else begin
                    mon_e = exp_q[0];
                    if (!head_seen) begin
                        chk("latency", cyc - mon_e.acc_cyc, mon_e.lat);
                        head_seen = 1'b1;
                    end
                    chk("rsp_data", bus.rsp_data, mon_e.data);
                    chk("rsp_id_err_cout", 32'({bus.rsp_id, bus.rsp_err, bus.rsp_cout}),
                        32'({mon_e.id, mon_e.err, mon_e.cout}));
                    if (bus.rsp_ready) begin
                        void'(exp_q.pop_front());
                        head_seen  = 1'b0;
                        model_idle = 1'b1;
                    end
                end
            end else if (exp_q.size() != 0 && (cyc - exp_q[0].acc_cyc) > exp_q[0].lat + 4) begin
                chk("rsp_timeout", cyc - exp_q[0].acc_cyc, exp_q[0].lat);
                void'(exp_q.pop_front());
                head_seen  = 1'b0;
                model_idle = 1'b1;
            end
            if (end_req && !end_done) begin
                chk("drain", 32'(exp_q.size()), 32'h0);
                end_done = 1'b1;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        took0 = bus.req0_valid && bus.req0_ready;
        took1 = bus.req1_valid && bus.req1_ready;
        @(posedge clk);
        #1;
        if (took0) bus.req0_valid = 1'b0;
        if (took1) bus.req1_valid = 1'b0;
    endtask

    task automatic issue(input bit port, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (port) begin
            bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1'b1;
        end else begin
            bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1'b1;
        end
    endtask

    task automatic run_until_quiet(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (!bus.req0_valid && !bus.req1_valid && exp_q.size() == 0) break;
            step();
        end
    endtask

    initial begin
        bus.req0_valid = 1'b0; bus.req0_op = 3'b000; bus.req0_a = 32'h0; bus.req0_b = 32'h0;
        bus.req1_valid = 1'b0; bus.req1_op = 3'b000; bus.req1_a = 32'h0; bus.req1_b = 32'h0;
        bus.rsp_ready  = 1'b1;

        // Reset with a request already waiting: ready must stay low throughout.
        #1 rst_n = 1'b0;
        issue(1'b0, 3'b100, 32'h1, 32'h1);
        repeat (3) @(posedge clk);
        #2;
        bus.req0_valid = 1'b0;
        rst_n = 1'b1;
        step();

        issue(1'b0, 3'b100, 32'hFFFF_FFFF, 32'h0000_0001);
        run_until_quiet(20);

        issue(1'b0, 3'b011, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        issue(1'b1, 3'b101, 32'h0000_0005, 32'h0000_0007);
        run_until_quiet(20);

        // Backpressure with a second request queued behind the held response.
        bus.rsp_ready = 1'b0;
        issue(1'b0, 3'b001, 32'h1234_5678, 32'h0F0F_0F0F);
        for (int i = 0; i < 10 && !bus.rsp_valid; i++) step();
        issue(1'b1, 3'b000, 32'h0000_FFFF, 32'h0);
        repeat (5) step();
        bus.rsp_ready = 1'b1;
        run_until_quiet(20);

        issue(1'b1, 3'b111, 32'hABCD_0123, 32'h4567_89AB);
        run_until_quiet(20);
        issue(1'b0, 3'b110, 32'h0001_2345, 32'h0000_0100);
        run_until_quiet(60);
        issue(1'b0, 3'b010, 32'h8000_0000, 32'h0000_0004);
        run_until_quiet(20);

        // The earlier tie left the pointer on port 1; a reset mid-EXEC must drop the op and re-arm it.
        issue(1'b1, 3'b100, 32'hAAAA_AAAA, 32'h5555_5555);
        took1 = 1'b0;
        for (int i = 0; i < 10 && !took1; i++) step();
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (4) step();
        issue(1'b0, 3'b011, 32'h1111_1111, 32'h2222_2222);
        issue(1'b1, 3'b100, 32'h7FFF_FFFF, 32'h0000_0001);
        run_until_quiet(20);

        for (int n = 0; n < 400; n++) begin
            if (!bus.req0_valid && $urandom_range(0, 2) == 0)
                issue(1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom);
            if (!bus.req1_valid && $urandom_range(0, 2) == 0)
                issue(1'b1, 3'($urandom_range(0, 7)), $urandom, 32'($urandom_range(0, 40)));
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        bus.rsp_ready = 1'b1;
        run_until_quiet(200);

        end_req = 1'b1;
        for (int i = 0; i < 5 && !end_done; i++) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog expired");
    end

endmodule
